sobel_frame_seq: RTL and testbench
==================================

Name: sobel_frame_seq

Overview:
- Front-end sequencer and result collector for the 32x32 Sobel frame memory.
- Accepts an input pixel stream over valid/ready and writes it into frame memory at addresses 0..1023 (wr_en/wr_addr/wr_data).
- Then sweeps rd_addr 0..1023 with sobel_en high and captures the returned gx/gy nibbles.
- Emits the results as an output stream with backpressure, and signals frame completion.

Parameters:
- PIX_W, 12, pixel/memory word width.
- ADDR_W, 10, frame address width.
- DEPTH, 1024, pixels per frame (32x32).
- G_W, 4, width of each gradient nibble from memory.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin frame (ignored unless IDLE).
- pix_valid  in  1  input pixel valid.
- pix_data  in  PIX_W  input pixel.
- pix_ready  out  1  high in LOAD only.
- wr_en  out  1  frame memory write strobe.
- wr_addr  out  ADDR_W  frame memory write address.
- wr_data  out  PIX_W  frame memory write data.
- sobel_en  out  1  high throughout RUN and DRAIN.
- rd_en  out  1  equals sobel_en.
- rd_addr  out  ADDR_W  Sobel centre address.
- gx_in  in  G_W  horizontal gradient; valid cycle after rd_addr issued.
- gy_in  in  G_W  vertical gradient; same timing as gx_in.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  2*G_W  {gy, gx}.
- res_addr  out  ADDR_W  pixel address of result.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse on last result accepted.

Behaviour:
- Reset (rst_n low at posedge): state IDLE. All outputs 0. Counters and skid buffer cleared. Applies mid-frame too; no partial results are emitted after reset.
- States: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
- IDLE: on start, wr counter = 0, go to LOAD.
- LOAD:
  - pix_ready = 1.
  - On pix_valid & pix_ready, register outputs for the next cycle: wr_en = 1, wr_addr = counter, wr_data = pix_data; counter++.
  - wr_en is 0 on cycles with no transfer.
  - After the transfer at counter 1023: counter and issue count clear, go to RUN. pix_ready drops the cycle after the last accept.
- RUN:
  - Issue rule: a new rd_addr (registered, incrementing from 0) is issued only when skid occupancy + in-flight < 2.
  - An issued address sets in-flight for exactly one cycle; the next cycle gx_in/gy_in are captured into the skid buffer with their address.
  - If the issue rule blocks, rd_addr holds its value. Memory keeps recomputing the same address; the repeated values are ignored.
  - After issuing address 1023, go to DRAIN. rd_addr holds 1023.
- DRAIN:
  - sobel_en stays high until the in-flight result is captured.
  - When the skid buffer is empty and the last result has been accepted: frame_done = 1 for one cycle, go to IDLE, sobel_en = 0.
- Skid buffer: 2 entries, FIFO order.
  - res_valid = not empty; head drives res_data/res_addr.
  - Pop on res_valid & res_ready.
  - Simultaneous capture and pop is allowed: occupancy unchanged.
  - Never overflows, by the issue rule.
- Throughput: with res_ready held high, one result per cycle. First result appears 2 cycles after RUN entry. 1024 results take ~1026 cycles.
- start during a non-IDLE state is ignored.
- pix_valid outside LOAD is ignored.
- res_ready low for any duration loses no data; res_data/res_addr are held stable while res_valid & !res_ready.
- Width rule: res_data[G_W-1:0] = gx_in, res_data[2*G_W-1:G_W] = gy_in, captured unmodified. Clamping is the memory block's job.

Decomposition:
- Shared package sobel_pkg: FRAME_DIM = 32, DEPTH = 1024, PIX_W/ADDR_W/G_W constants, state enum {IDLE, LOAD, RUN, DRAIN}.
- One sub-module: sobel_res_skid, a 2-entry FIFO of {addr, gy, gx} with valid/ready output, push input and occupancy output.
- Sequencer FSM and counters stay in sobel_frame_seq.

Test Plan:
- Reset mid-LOAD after 100 pixels, then rst_n low one cycle -> next cycle busy = 0, pix_ready = 0, wr_en = 0; new start reloads from wr_addr 0.
- Load 1024 pixels pix_data = address, pix_valid constant -> wr_addr/wr_data = 0..1023 consecutively, one per cycle; pix_ready low after 1024th accept; RUN entered.
- Random pix_valid gaps (50%) -> wr_en only on accepts; writes are still 0..1023 in order with no duplicates.
- RUN with res_ready = 1 and model memory returning gx = addr[3:0], gy = ~addr[3:0] -> 1024 results, res_addr 0..1023 in order, each res_data correct; frame_done pulses exactly once.
- res_ready toggling randomly plus 20-cycle stall at addr 500 -> no loss or duplication; res_data stable while stalled; rd_addr held during the stall.
- start pulsed during RUN -> ignored, frame completes normally; start in IDLE afterwards begins a new LOAD.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel frame sequencer.
//   FRAME_DIM/DEPTH : frame geometry (32x32 pixels)
//   PIX_W/ADDR_W/G_W: pixel word, frame address and gradient nibble widths
//   seq_state_e     : sequencer states
//   res_t           : one captured result {addr, gy, gx}
package sobel_pkg;

  localparam int FRAME_DIM = 32;
  localparam int DEPTH     = FRAME_DIM * FRAME_DIM;
  localparam int PIX_W     = 12;
  localparam int ADDR_W    = 10;
  localparam int G_W       = 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [G_W-1:0]    gy;
    logic [G_W-1:0]    gx;
  } res_t;

endpackage

// File: rtl/sobel_frame_seq_if.sv
// Bundle of every non-clock signal of sobel_frame_seq.
//   master : sequencer side (drives pixel ready, memory write/read, results)
//   slave  : environment side (pixel source, frame memory, result sink)
interface sobel_frame_seq_if;
  import sobel_pkg::*;

  // control
  logic              start;
  logic              busy;
  logic              frame_done;
  // input pixel stream
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  // frame memory write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  // frame memory Sobel read port
  logic              sobel_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [G_W-1:0]    gx_in;
  logic [G_W-1:0]    gy_in;
  // result stream
  logic              res_valid;
  logic              res_ready;
  logic [2*G_W-1:0]  res_data;
  logic [ADDR_W-1:0] res_addr;

  modport master (
    input  start, pix_valid, pix_data, gx_in, gy_in, res_ready,
    output busy, frame_done, pix_ready, wr_en, wr_addr, wr_data,
           sobel_en, rd_en, rd_addr, res_valid, res_data, res_addr
  );

  modport slave (
    output start, pix_valid, pix_data, gx_in, gy_in, res_ready,
    input  busy, frame_done, pix_ready, wr_en, wr_addr, wr_data,
           sobel_en, rd_en, rd_addr, res_valid, res_data, res_addr
  );

endinterface

// File: rtl/sobel_res_skid.sv
// Two-entry FIFO holding captured Sobel results until downstream accepts them.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_data this cycle (caller guarantees no overflow)
//   i_data     : result {addr, gy, gx} to store
//   o_valid    : FIFO not empty; o_data is the oldest entry
//   i_ready    : downstream accepts o_data (pop when o_valid & i_ready)
//   o_occ      : number of stored entries (0..2)
module sobel_res_skid
  import sobel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  res_t       i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output res_t       o_data,
  output logic [1:0] o_occ
);

  res_t       r_entry [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;
  logic       w_pop;

  assign w_pop = o_valid & i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage is cleared as well, because o_data is visible on
      // the result port and must read zero straight after reset.
      for (int i = 0; i < 2; i++) r_entry[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_entry[r_wr_ptr] <= i_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      // simultaneous push and pop leaves occupancy unchanged
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_entry[r_rd_ptr];
  assign o_occ   = r_occ;

endmodule

// File: rtl/sobel_frame_seq.sv
// Frame sequencer for the 32x32 Sobel frame memory: loads a pixel stream
// into memory, sweeps the Sobel read address over the frame, and streams
// the returned {gy, gx} results out with backpressure.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sobel_frame_seq_if.master (start/busy/frame_done, pixel
//                stream, memory write port, Sobel read port, result stream)
module sobel_frame_seq
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  sobel_frame_seq_if.master bus
);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_in_flight;
  logic              r_frame_done;

  logic [1:0]        w_occ;
  logic              w_res_valid;
  logic              w_pop;
  logic              w_can_issue;
  logic              w_last_pop;
  res_t              w_cap;
  res_t              w_head;

  assign w_pop = w_res_valid & bus.res_ready;

  // A result popped this cycle frees its slot at the same edge the next
  // address is issued, which is what sustains one result per cycle.
  assign w_can_issue = (r_state == RUN) &&
                       (({1'b0, w_occ} + {2'b00, r_in_flight}) < (3'd2 + {2'b00, w_pop}));

  // In DRAIN nothing is left to issue; the frame ends when the only
  // remaining entry leaves and nothing is still in flight.
  assign w_last_pop = (r_state == DRAIN) && !r_in_flight && (w_occ == 2'd1) && w_pop;

  // rd_addr still holds the issued address during the in-flight cycle.
  assign w_cap = '{addr: r_rd_addr, gy: bus.gy_in, gx: bus.gx_in};

  sobel_res_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_in_flight),
    .i_data  (w_cap),
    .o_valid (w_res_valid),
    .i_ready (bus.res_ready),
    .o_data  (w_head),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wr_cnt     <= '0;
      r_issue_cnt  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_addr    <= '0;
      r_in_flight  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_in_flight  <= w_can_issue;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_wr_cnt <= '0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          // pix_ready is high throughout LOAD, so pix_valid alone is a transfer
          if (bus.pix_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_wr_cnt;
            r_wr_data <= bus.pix_data;
            r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
            if (r_wr_cnt == LAST_ADDR) begin
              r_wr_cnt    <= '0;
              r_issue_cnt <= '0;
              r_rd_addr   <= '0;
              r_state     <= RUN;
            end
          end
        end
        RUN: begin
          if (w_can_issue) begin
            r_rd_addr   <= r_issue_cnt;
            r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
            if (r_issue_cnt == LAST_ADDR) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last_pop) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are either registers or plain decodes of the state register.
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.pix_ready  = (r_state == LOAD);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.sobel_en   = (r_state == RUN) || (r_state == DRAIN);
  assign bus.rd_en      = bus.sobel_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.res_valid  = w_res_valid;
  assign bus.res_data   = {w_head.gy, w_head.gx};
  assign bus.res_addr   = w_head.addr;

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Self-checking bench for sobel_frame_seq: a behavioural frame memory
// (written through wr_*, read combinationally at rd_addr) and a reference
// expectation of the result stream derived from the pixels sent.
module tb_sobel_frame_seq;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  sobel_frame_seq_if bus ();

  sobel_frame_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] frame_px [DEPTH];  // pixels the bench sends
  logic [PIX_W-1:0] pmem     [DEPTH];  // frame memory model

  always @(posedge clk) if (bus.wr_en) pmem[bus.wr_addr] <= bus.wr_data;

  // memory returns gx = pixel[3:0], gy = ~pixel[3:0] at the current address
  assign bus.gx_in = pmem[bus.rd_addr][G_W-1:0];
  assign bus.gy_in = ~pmem[bus.rd_addr][G_W-1:0];

  function automatic logic [2*G_W-1:0] exp_res(input int i);
    logic [G_W-1:0] g;
    g = frame_px[i][G_W-1:0];
    return {~g, g};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame and sends n_px pixels with gap_pct% idle cycles.
  task automatic load_frame(input bit rand_px, input int gap_pct, input int n_px);
    int n;
    int cyc;
    bit v;
    for (int i = 0; i < DEPTH; i++) frame_px[i] = rand_px ? PIX_W'($urandom) : PIX_W'(i);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("load_busy", 32'(bus.busy), 32'd1);
    n   = 0;
    cyc = 0;
    while (n < n_px) begin
      if (cyc >= 8 * DEPTH) begin
        check("load_timeout", 32'(n), 32'(n_px));
        break;
      end
      v = ($urandom_range(99) >= gap_pct);
      bus.pix_valid = v;
      bus.pix_data  = v ? frame_px[n] : PIX_W'($urandom);
      check("pix_ready_load", 32'(bus.pix_ready), 32'd1);
      step();
      cyc++;
      check("wr_en", 32'(bus.wr_en), 32'(v));
      if (v) begin
        check("wr_addr", 32'(bus.wr_addr), 32'(n));
        check("wr_data", 32'(bus.wr_data), 32'(frame_px[n]));
        n++;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  // Drains one frame's results; returns cycles from RUN entry to last accept.
  task automatic collect(input int ready_pct, input bit stall500, input int start_at,
                         output int cycles, output int first_valid);
    int idx;
    int cyc;
    int stall_left;
    int stall_age;
    bit stalled_once;
    idx = 0; cyc = 0; stall_left = 0; stall_age = 0; stalled_once = 1'b0;
    first_valid = -1;
    while (idx < DEPTH) begin
      if (cyc >= 20 * DEPTH) begin
        check("collect_timeout", 32'(idx), 32'(DEPTH));
        break;
      end
      bus.start = (cyc == start_at);
      if (stall500 && !stalled_once && idx == 500 && bus.res_valid === 1'b1) begin
        stalled_once = 1'b1;
        stall_left   = 20;
        stall_age    = 0;
      end
      if (stall_left > 0) begin
        bus.res_ready = 1'b0;
        stall_left--;
        stall_age++;
        if (stall_age >= 3) begin
          // buffer full with idx and idx+1; nothing more may be issued
          check("stall_rd_addr", 32'(bus.rd_addr), 32'(idx + 1));
          check("stall_valid", 32'(bus.res_valid), 32'd1);
        end
      end else begin
        bus.res_ready = ($urandom_range(99) < ready_pct);
      end
      check("busy_run", 32'(bus.busy), 32'd1);
      check("sobel_en_run", 32'(bus.sobel_en), 32'd1);
      check("frame_done_early", 32'(bus.frame_done), 32'd0);
      if (bus.res_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        check("res_addr", 32'(bus.res_addr), 32'(idx));
        check("res_data", 32'(bus.res_data), 32'(exp_res(idx)));
        if (bus.res_ready) idx++;
      end
      step();
      cyc++;
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    cycles        = cyc;
    check("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd0);
    check("sobel_en_done", 32'(bus.sobel_en), 32'd0);
    check("res_valid_done", 32'(bus.res_valid), 32'd0);
    check("rd_addr_last", 32'(bus.rd_addr), 32'(DEPTH - 1));
    step();
    check("frame_done_once", 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    int first;

    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.res_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_sobel_en", 32'(bus.sobel_en), 32'd0);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_addr", 32'(bus.res_addr), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;

    // pix_valid in IDLE is ignored
    bus.pix_valid = 1'b1;
    bus.pix_data  = 12'hABC;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_wr_en", 32'(bus.wr_en), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.pix_valid = 1'b0;

    // reset mid-LOAD after 100 pixels
    load_frame(1'b1, 0, 100);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);

    // frame A: pixel = address, no gaps, res_ready held high
    load_frame(1'b0, 0, DEPTH);
    check("a_pix_ready_low", 32'(bus.pix_ready), 32'd0);
    check("a_sobel_en", 32'(bus.sobel_en), 32'd1);
    check("a_rd_en", 32'(bus.rd_en), 32'd1);
    collect(100, 1'b0, -1, cycles, first);
    check("a_first_latency", 32'(first), 32'd2);
    check("a_cycles", 32'(cycles), 32'(DEPTH + 2));

    // frame B: random pixels, 50% input gaps, random backpressure + stall at 500
    load_frame(1'b1, 50, DEPTH);
    check("b_pix_ready_low", 32'(bus.pix_ready), 32'd0);
    collect(60, 1'b1, -1, cycles, first);

    // frame C: start pulsed during RUN is ignored
    load_frame(1'b1, 0, DEPTH);
    collect(80, 1'b0, 10, cycles, first);

    // start in IDLE begins a new LOAD
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_pix_ready", 32'(bus.pix_ready), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("final_rst_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
